joy_move_ctrl: RTL

JOY_MOVE_CTRL -- requirements
Module: joy_move_ctrl

---
 rtl/joy_move_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/joy_move_ctrl.sv
// Joystick-driven position controller: synchronize and debounce four switches, step a
// saturating x/y position on press and at a fixed repeat rate, publish it on vsync edges.
module joy_move_ctrl #(
  parameter int TICK_DIV = 5000000,
  parameter int DEB_LEN  = 250000,
  parameter int X_MAX    = 639,
  parameter int Y_MAX    = 479,
  parameter int X_INIT   = 320,
  parameter int Y_INIT   = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  input  logic       up,
  input  logic       down,
  input  logic       vsync,
  output logic [9:0] player_x,
  output logic [9:0] player_y,
  output logic       moving
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_LEN - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  // Direction bit order: [3]=left [2]=right [1]=up [0]=down
  logic [3:0]    raw, sync1, sync2, deb;
  logic [DW-1:0] deb_cnt [4];
  state_t        state;
  logic [TW-1:0] tick;
  logic [9:0]    joy_x, joy_y, nxt_x, nxt_y;
  logic          vsync_prev;

  assign raw = {left, right, up, down};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != deb[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            deb[i]     <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Position one step away in the highest-priority held direction, saturating at the edges.
  always_comb begin
    nxt_x = joy_x;
    nxt_y = joy_y;
    if (deb[3]) begin
      if (joy_x != 10'd0) nxt_x = joy_x - 10'd1;
    end else if (deb[2]) begin
      if (joy_x < 10'(X_MAX)) nxt_x = joy_x + 10'd1;
    end else if (deb[1]) begin
      if (joy_y != 10'd0) nxt_y = joy_y - 10'd1;
    end else if (deb[0]) begin
      if (joy_y < 10'(Y_MAX)) nxt_y = joy_y + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      moving <= 1'b0;
      tick   <= '0;
      joy_x  <= 10'(X_INIT);
      joy_y  <= 10'(Y_INIT);
    end else begin
      unique case (state)
        IDLE: begin
          tick <= '0;
          if (|deb) begin
            joy_x  <= nxt_x;
            joy_y  <= nxt_y;
            state  <= HOLD;
            moving <= 1'b1;
          end
        end
        HOLD: begin
          // Release beats a coincident tick; direction changes keep the running count.
          if (!(|deb)) begin
            state  <= IDLE;
            moving <= 1'b0;
            tick   <= '0;
          end else if (tick == TICK_LAST) begin
            joy_x <= nxt_x;
            joy_y <= nxt_y;
            tick  <= '0;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          moving <= 1'b0;
          tick   <= '0;
        end
      endcase
    end
  end

  // Nonblocking load picks up the pre-step joy value when a step lands on the edge cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_prev <= 1'b0;
      player_x   <= 10'(X_INIT);
      player_y   <= 10'(Y_INIT);
    end else begin
      vsync_prev <= vsync;
      if (vsync && !vsync_prev) begin
        player_x <= joy_x;
        player_y <= joy_y;
      end
    end
  end

endmodule
